// File: rtl/secure_reg_access_ctrl_if.sv
// rtl/secure_reg_access_ctrl_if.sv - request/response, register-side and status signals of the secure register front-end
interface secure_reg_access_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int VIOL_CNT_WIDTH = 4
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic                      req_thread_id;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;
  logic                      reg_wr_en;
  logic                      reg_access_en;
  logic                      reg_thread_id;
  logic [DATA_WIDTH-1:0]     reg_data_in;
  logic [DATA_WIDTH-1:0]     reg_data_out;
  logic [VIOL_CNT_WIDTH-1:0] viol_count;
  logic                      lockout;

  modport slave (
    input  req_valid, req_write, req_thread_id, req_wdata, resp_ready, reg_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output reg_wr_en, reg_access_en, reg_thread_id, reg_data_in, viol_count, lockout
  );

  modport master (
    output req_valid, req_write, req_thread_id, req_wdata, resp_ready, reg_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  reg_wr_en, reg_access_en, reg_thread_id, reg_data_in, viol_count, lockout
  );
endinterface

// File: rtl/secure_reg_access_ctrl.sv
// rtl/secure_reg_access_ctrl.sv - thread-gated request front-end with denial counting and sticky lockout
module secure_reg_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int VIOL_CNT_WIDTH = 4,
  parameter int LOCKOUT_THRESH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  secure_reg_access_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  localparam logic [VIOL_CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [VIOL_CNT_WIDTH-1:0] THRESH_C = VIOL_CNT_WIDTH'(LOCKOUT_THRESH);

  state_e                    state_q;
  logic                      req_ready_q;
  logic                      write_q;
  logic                      grant_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [DATA_WIDTH-1:0]     resp_rdata_q;
  logic                      reg_wr_en_q;
  logic                      reg_access_en_q;
  logic [DATA_WIDTH-1:0]     reg_data_in_q;
  logic [VIOL_CNT_WIDTH-1:0] viol_cnt_q;
  logic                      lockout_q;

  logic [VIOL_CNT_WIDTH-1:0] viol_cnt_d;
  logic                      lockout_d;
  logic                      grant_d;

  always_comb begin
    viol_cnt_d = (viol_cnt_q == CNT_MAX) ? viol_cnt_q : viol_cnt_q + VIOL_CNT_WIDTH'(1);
    lockout_d  = lockout_q | (viol_cnt_d >= THRESH_C);
    grant_d    = (bus.req_thread_id == 1'b0) && !lockout_q;
  end

  // Grant is decided at acceptance so the register strobe is already registered in ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      req_ready_q     <= 1'b1;
      write_q         <= 1'b0;
      grant_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
      reg_wr_en_q     <= 1'b0;
      reg_access_en_q <= 1'b0;
      reg_data_in_q   <= '0;
      viol_cnt_q      <= '0;
      lockout_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= bus.req_write;
            grant_q     <= grant_d;
            if (grant_d) begin
              reg_access_en_q <= 1'b1;
              reg_wr_en_q     <= bus.req_write;
              reg_data_in_q   <= bus.req_wdata;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          reg_access_en_q <= 1'b0;
          reg_wr_en_q     <= 1'b0;
          reg_data_in_q   <= '0;
          if (grant_q) begin
            state_q <= CAPTURE;
          end else begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            resp_valid_q <= 1'b1;
            viol_cnt_q   <= viol_cnt_d;
            lockout_q    <= lockout_d;
            state_q      <= RESP;
          end
        end
        CAPTURE: begin
          resp_rdata_q <= write_q ? '0 : bus.reg_data_out;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.reg_wr_en     = reg_wr_en_q;
  assign bus.reg_access_en = reg_access_en_q;
  // Only thread 0 is ever granted, so the register never sees another id.
  assign bus.reg_thread_id = 1'b0;
  assign bus.reg_data_in   = reg_data_in_q;
  assign bus.viol_count    = viol_cnt_q;
  assign bus.lockout       = lockout_q;
endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// tb/tb_secure_reg_access_ctrl.sv - directed scoreboard bench for secure_reg_access_ctrl
module tb_secure_reg_access_ctrl;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk_i;
  logic rst_ni;

  secure_reg_access_ctrl_if #(.DATA_WIDTH(DW), .VIOL_CNT_WIDTH(CW)) bus ();

  secure_reg_access_ctrl #(
    .DATA_WIDTH(DW), .VIOL_CNT_WIDTH(CW), .LOCKOUT_THRESH(8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [CW-1:0] model_cnt  = '0;
  logic          model_lock = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  {31'd0, bus.req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_resp_err"},   {31'd0, bus.resp_err}, 32'd0);
    chk({tag, "_access_en"},  {31'd0, bus.reg_access_en}, 32'd0);
    chk({tag, "_wr_en"},      {31'd0, bus.reg_wr_en}, 32'd0);
    chk({tag, "_data_in"},    bus.reg_data_in, 32'd0);
    chk({tag, "_viol"},       {28'd0, bus.viol_count}, 32'd0);
    chk({tag, "_lockout"},    {31'd0, bus.lockout}, 32'd0);
  endtask

  task automatic do_req(input string tag, input logic wr, input logic tid,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rd_val,
                        input int stall);
    logic          grant;
    exp_t          e;
    exp_t          got;
    int            lat;
    logic [DW-1:0] held;
    grant = (tid == 1'b0) && !model_lock;
    e.err   = !grant;
    e.rdata = (grant && !wr) ? rd_val : '0;
    if (!grant) begin
      if (model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
      if (model_cnt >= 4'd8) model_lock = 1'b1;
    end

    @(negedge clk_i);
    chk({tag, "_ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid     = 1'b1;
    bus.req_write     = wr;
    bus.req_thread_id = tid;
    bus.req_wdata     = wdata;
    sb.push_back(e);
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid    = 1'b0;
    bus.req_wdata    = $urandom;
    bus.reg_data_out = rd_val;
    chk({tag, "_access_en"}, {31'd0, bus.reg_access_en}, {31'd0, grant});
    chk({tag, "_wr_en"},     {31'd0, bus.reg_wr_en}, {31'd0, grant & wr});
    chk({tag, "_data_in"},   bus.reg_data_in, grant ? wdata : 32'd0);
    chk({tag, "_thread_id"}, {31'd0, bus.reg_thread_id}, 32'd0);
    chk({tag, "_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);

    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(negedge clk_i);
      lat++;
      if (lat == 2) chk({tag, "_access_drop"}, {31'd0, bus.reg_access_en}, 32'd0);
    end
    chk({tag, "_latency"}, lat, grant ? 32'd3 : 32'd2);
    chk({tag, "_viol"},    {28'd0, bus.viol_count}, {28'd0, model_cnt});
    chk({tag, "_lockout"}, {31'd0, bus.lockout}, {31'd0, model_lock});

    held = bus.resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk({tag, "_stall_valid"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, "_stall_rdata"}, bus.resp_rdata, held);
      chk({tag, "_stall_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end

    got.rdata = bus.resp_rdata;
    got.err   = bus.resp_err;
    e = sb.pop_front();
    chk({tag, "_rdata"}, got.rdata, e.rdata);
    chk({tag, "_err"},   {31'd0, got.err}, {31'd0, e.err});
    bus.resp_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.resp_ready = 1'b0;
    chk({tag, "_valid_clr"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_back_idle"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    rst_ni            = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_write     = 1'b0;
    bus.req_thread_id = 1'b0;
    bus.req_wdata     = '0;
    bus.resp_ready    = 1'b0;
    bus.reg_data_out  = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_ni = 1'b1;

    do_req("wr_t0",   1'b1, 1'b0, 32'hDEADBEEF, 32'h0000_0000, 0);
    do_req("rd_t0",   1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 0);
    do_req("wr_t1",   1'b1, 1'b1, 32'h12345678, 32'hFFFF_FFFF, 0);
    do_req("rd_stall", 1'b0, 1'b0, 32'h0,       32'hA5A5_1234, 10);
    for (int i = 0; i < 7; i++)
      do_req("deny_t1", i[0], 1'b1, $urandom, $urandom, 0);
    do_req("locked_t0", 1'b1, 1'b0, 32'hCAFEF00D, 32'h1111_2222, 0);
    for (int i = 0; i < 11; i++)
      do_req("sat", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 0);
    chk("sat_final", {28'd0, bus.viol_count}, 32'd15);

    // Reset during CAPTURE of a granted read
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_cnt  = '0;
    model_lock = 1'b0;
    @(negedge clk_i);
    bus.req_valid     = 1'b1;
    bus.req_write     = 1'b0;
    bus.req_thread_id = 1'b0;
    bus.req_wdata     = 32'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid    = 1'b0;
    bus.reg_data_out = 32'h5555_AAAA;
    chk("mid_issue_access", {31'd0, bus.reg_access_en}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("post_rst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    chk_reset_outputs("post_rst");

    do_req("after_rst_wr", 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/secure_reg_access_ctrl.md
# secure_reg_access_ctrl

Request front-end that sits directly upstream of the thread-gated secure register and is the only agent driving its write-enable, access-enable, thread-id and data inputs. It accepts one read or write request at a time over a valid/ready channel, checks the requesting thread, issues a single-cycle access to the register only for thread 0, and returns the result over a valid/ready response channel. It also keeps a saturating count of denied requests and raises a sticky lockout after a threshold, after which every request is denied.

## Interface

- DATA_WIDTH, 32, width of request, response and register data
- VIOL_CNT_WIDTH, 4, width of the denied-request counter
- LOCKOUT_THRESH, 8, count value at which lockout asserts; legal range 1 to 2^VIOL_CNT_WIDTH-1

- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_thread_id  in  1  requesting thread
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when high together with resp_valid
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and denials
- resp_err  out  1  1 = request denied
- reg_wr_en  out  1  to secure register write enable
- reg_access_en  out  1  to secure register access enable
- reg_thread_id  out  1  to secure register thread id
- reg_data_in  out  DATA_WIDTH  to secure register write data
- reg_data_out  in  DATA_WIDTH  from secure register read data
- viol_count  out  VIOL_CNT_WIDTH  denied-request count, saturating
- lockout  out  1  sticky lockout flag

## Operation

- All outputs are registered. Reset value of every output: 0, except req_ready, which is 1 (state IDLE).
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready = 1. On req_valid & req_ready, capture req_write, req_thread_id and req_wdata, then go to ISSUE. No other state accepts a request (req_ready = 0).
- ISSUE, grant case (captured thread_id == 0 and lockout == 0):
  - For exactly one cycle, drive reg_access_en = 1, reg_wr_en = captured write, reg_thread_id = 0, reg_data_in = captured wdata.
  - Go to CAPTURE.
- ISSUE, deny case (any other condition):
  - reg_* stays 0; the register is never touched.
  - Load resp_err = 1 and resp_rdata = 0.
  - viol_count increments, holding at 2^VIOL_CNT_WIDTH-1.
  - Go to RESP.
- CAPTURE: reg_access_en and reg_wr_en return to 0.
  - Read: resp_rdata = reg_data_out sampled this cycle.
  - Write: resp_rdata = 0.
  - resp_err = 0. Go to RESP.
- RESP: resp_valid = 1. resp_rdata and resp_err hold stable until resp_ready. On resp_valid & resp_ready, clear resp_valid and go to IDLE.
- lockout: sets on the cycle viol_count becomes >= LOCKOUT_THRESH. Clears only on reset. Denials during lockout still increment the count (saturating).
- reg_data_in and reg_thread_id return to 0 whenever reg_access_en is 0. The controller never presents a nonzero thread_id to the register.

## Timing

- A request accepted at edge T:
  - Grant: reg_access_en high in cycle T+1, resp_valid high from T+3.
  - Deny: resp_valid high from T+2, with viol_count updated at T+2.
- resp_ready held high gives back-to-back throughput of:
  - granted: one request per 4 cycles
  - denied: one request per 3 cycles
- resp_valid stays asserted indefinitely under back-pressure. No new request is accepted until the response is taken.
- Reset asserted mid-operation:
  - Immediately returns to IDLE, with all outputs at reset values.
  - The in-flight request is dropped with no response.
  - viol_count and lockout clear.
- A denial that takes viol_count from LOCKOUT_THRESH-1 to LOCKOUT_THRESH sets lockout in that same cycle. The next thread-0 request is denied.

## Test plan

- Reset, then thread 0 writes 0xDEADBEEF → reg_access_en = 1, reg_wr_en = 1, reg_data_in = 0xDEADBEEF for exactly one cycle; response has resp_err = 0 and resp_rdata = 0.
- Thread 0 read, with reg_data_out = 0xDEADBEEF in CAPTURE → resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid at T+3.
- Thread 1 write of 0x12345678 → reg_access_en never asserts; response has resp_err = 1 and resp_rdata = 0; viol_count goes 0 → 1 at T+2.
- 8 thread-1 requests → lockout rises with the 8th response; a following thread-0 write is denied with no register access. 20 denials leave viol_count saturated at 15.
- resp_ready held low for 10 cycles in RESP → resp_valid and resp_rdata stay stable and req_ready stays 0. On release, IDLE is reached the next cycle.
- rst_n pulsed low during CAPTURE → all outputs return to reset values immediately, no response is issued, and viol_count = 0 and lockout = 0.
